attocore_mem_ctrl: RTL

- Bus master sitting directly upstream of the 1024x8 synchronous RAM: sole driver of its address, cs, rw and shared tristate data bus.
- CPU side gets a valid/ready request channel with bursts, a write-data channel and a read-data return.
- Hides the RAM's one-cycle read latency and bus turnaround; streams burst reads at one byte per cycle.

---
 rtl/attocore_pkg.sv | 19 +
 rtl/attocore_mem_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/attocore_pkg.sv
// Shared definitions for the attocore memory controller and its CPU-side sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package attocore_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    // Controller state; also decoded by the CPU sequencer, so keep the order stable.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/attocore_mem_ctrl.sv
// Burst master for the 1024x8 synchronous RAM; sole owner of its address/cs/rw/data bus.
// Latency: first read beat returns on o_rd_valid 3 cycles after acceptance, then 1 beat/cycle.
// Backpressure: o_req_ready only in IDLE; write beats stall on i_wr_valid; reads cannot be stalled.
module attocore_mem_ctrl #(
    parameter int ADDR_W = attocore_pkg::ADDR_W,
    parameter int DATA_W = attocore_pkg::DATA_W,
    parameter int LEN_W  = attocore_pkg::LEN_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_address,
    inout  wire  [DATA_W-1:0] io_ram_data,
    output logic              o_ram_cs,
    output logic              o_ram_rw
);

    import attocore_pkg::*;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [LEN_W-1:0]    r_beats_left;
    // High in the cycle the RAM presents data for a beat issued in the previous cycle.
    logic                r_rd_pend;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    logic                w_read_phase;
    logic                w_write_phase;

    assign w_read_phase  = (r_state == READ) || (r_state == DRAIN);
    assign w_write_phase = (r_state == WRITE);

    // Transaction sequencing: address/beat counting and the IDLE->op->GAP walk.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_cur_addr   <= i_req_addr;
                        r_beats_left <= i_req_len;
                        r_state      <= i_req_write ? WRITE : READ;
                    end
                end
                READ: begin
                    // Last beat keeps its address so DRAIN re-reads a harmless location.
                    if (r_beats_left == '0) begin
                        r_state <= DRAIN;
                    end else begin
                        r_cur_addr   <= r_cur_addr + 1'b1;
                        r_beats_left <= r_beats_left - 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= GAP;
                end
                WRITE: begin
                    if (i_wr_valid) begin
                        r_cur_addr   <= r_cur_addr + 1'b1;
                        r_beats_left <= r_beats_left - 1'b1;
                        if (r_beats_left == '0) begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read return pipeline: capture the RAM output one cycle after each READ issue.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= (r_state == READ);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= io_ram_data;
            end
        end
    end

    assign o_req_ready   = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_wr_ready    = w_write_phase;
    assign o_ram_rw      = w_write_phase;
    assign o_ram_cs      = w_read_phase || (w_write_phase && i_wr_valid);
    assign o_ram_address = r_cur_addr;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;

    // Bus is released whenever the RAM might be driving it.
    assign io_ram_data = (o_ram_cs && o_ram_rw) ? i_wr_data : {DATA_W{1'bz}};

endmodule
